// File: rtl/oci_dct_pkg.sv
// Shared definitions for the data cycle trace controller: FSM encoding,
// trace word layout and payload widths.
package oci_dct_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ARMED = 2'd1,
    ST_POST  = 2'd2,
    ST_DONE  = 2'd3
  } dct_state_e;

  localparam int DCT_BUF_W   = 30;
  localparam int DCT_CNT_W   = 4;
  localparam int TW_DATA_W   = 36;
  localparam int TW_BUF_LSB  = 0;
  localparam int TW_CNT_LSB  = 30;
  localparam int TW_WRAP_BIT = 34;
  localparam int TW_TRIG_BIT = 35;

  function automatic logic [TW_DATA_W-1:0] pack_tw_word(
    input logic                 trig_mark,
    input logic                 wrap,
    input logic [DCT_CNT_W-1:0] cnt,
    input logic [DCT_BUF_W-1:0] payload
  );
    logic [TW_DATA_W-1:0] w;
    w = {TW_DATA_W{1'b0}};
    w[TW_BUF_LSB +: DCT_BUF_W] = payload;
    w[TW_CNT_LSB +: DCT_CNT_W] = cnt;
    w[TW_WRAP_BIT]             = wrap;
    w[TW_TRIG_BIT]             = trig_mark;
    return w;
  endfunction

endpackage

// File: rtl/oci_dct_trace_ctrl_if.sv
// Trace RAM write channel between the trace controller (master) and the
// RAM arbiter (slave).
interface oci_dct_trace_ctrl_if
  import oci_dct_pkg::*;
#(
  parameter int ADDR_W = 7
) ();

  logic                 tw_wr;
  logic [ADDR_W-1:0]    tw_addr;
  logic [TW_DATA_W-1:0] tw_data;
  logic                 tw_ack;

  modport master (output tw_wr, output tw_addr, output tw_data, input tw_ack);
  modport slave  (input tw_wr, input tw_addr, input tw_data, output tw_ack);

endinterface

// File: rtl/oci_dct_hold_reg.sv
// Single-entry holding register for trace RAM writes: presents one word until
// acked, accepts a new word in the ack cycle, and flags entries lost while full.
module oci_dct_hold_reg
  import oci_dct_pkg::*;
#(
  parameter int ADDR_W = 7
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 clr,
  input  logic                 load_req,
  input  logic [ADDR_W-1:0]    load_addr,
  input  logic [TW_DATA_W-1:0] load_data,
  input  logic                 ack,
  output logic                 wr,
  output logic [ADDR_W-1:0]    addr,
  output logic [TW_DATA_W-1:0] data,
  output logic                 overflow,
  output logic                 loaded
);

  logic                 wr_r;
  logic [ADDR_W-1:0]    addr_r;
  logic [TW_DATA_W-1:0] data_r;
  logic                 overflow_r;
  logic                 drop_s;

  // The register frees up in the same cycle its current word is acked.
  assign loaded = load_req & (~wr_r | ack);
  assign drop_s = load_req & wr_r & ~ack;

  // Holding register, handshake and sticky overflow.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_r       <= 1'b0;
      addr_r     <= {ADDR_W{1'b0}};
      data_r     <= {TW_DATA_W{1'b0}};
      overflow_r <= 1'b0;
    end else begin
      if (loaded) begin
        wr_r   <= 1'b1;
        addr_r <= load_addr;
        data_r <= load_data;
      end else if (ack) begin
        wr_r <= 1'b0;
      end
      if (clr) begin
        overflow_r <= 1'b0;
      end else if (drop_s) begin
        overflow_r <= 1'b1;
      end
    end
  end

  assign wr       = wr_r;
  assign addr     = addr_r;
  assign data     = data_r;
  assign overflow = overflow_r;

endmodule

// File: rtl/oci_dct_trace_ctrl.sv
// Data cycle trace capture controller: arm/trigger FSM, circular write pointer
// and post-trigger count. Define OCI_DCT_COMPRESS_EN to suppress repeated entries.
module oci_dct_trace_ctrl
  import oci_dct_pkg::*;
#(
  parameter int ADDR_W    = 7,
  parameter int POST_TRIG = 64
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic [DCT_BUF_W-1:0] dct_buffer,
  input  logic [DCT_CNT_W-1:0] dct_count,
  input  logic                 dct_valid,
  input  logic                 arm,
  input  logic                 trig,
  input  logic                 test_ending,
  oci_dct_trace_ctrl_if.master tw,
  output logic [1:0]           state,
  output logic                 wrapped,
  output logic                 overflow,
  output logic [ADDR_W-1:0]    trig_addr
);

  localparam logic [ADDR_W-1:0] PTR_ONE   = {{(ADDR_W-1){1'b0}}, 1'b1};
  localparam logic [ADDR_W-1:0] PTR_MAX   = {ADDR_W{1'b1}};
  localparam logic [ADDR_W-1:0] POST_LAST = ADDR_W'(POST_TRIG - 1);

  dct_state_e           state_r, state_next_s;
  logic [ADDR_W-1:0]    wr_ptr_r, post_cnt_r, trig_addr_r, load_addr_s, hold_addr_s;
  logic [TW_DATA_W-1:0] load_data_s, hold_data_s;
  logic                 wrapped_r, trig_pend_r, pend_post_r, ending_r;
  logic                 hold_wr_s, hold_loaded_s, overflow_s, done_s, wrap_evt_s;
  logic                 ending_s, arm_go_s, trig_take_s, cap_ok_s, cap_req_s;
  logic                 post_ack_s, final_ack_s, mark_s, suppress_s;

  assign done_s      = hold_wr_s & tw.tw_ack;
  assign wrap_evt_s  = done_s & (wr_ptr_r == PTR_MAX);
  assign load_addr_s = done_s ? (wr_ptr_r + PTR_ONE) : wr_ptr_r;
  assign mark_s      = trig_take_s | trig_pend_r;
  assign load_data_s = pack_tw_word(mark_s, wrapped_r | wrap_evt_s, dct_count, dct_buffer);
  assign cap_req_s   = cap_ok_s & dct_valid & ~suppress_s;

`ifdef OCI_DCT_COMPRESS_EN
  logic [DCT_CNT_W+DCT_BUF_W-1:0] last_r;
  logic                           last_vld_r;

  // Last captured payload, forgotten on every arm.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      last_r     <= {(DCT_CNT_W+DCT_BUF_W){1'b0}};
      last_vld_r <= 1'b0;
    end else if (arm_go_s) begin
      last_vld_r <= 1'b0;
    end else if (hold_loaded_s) begin
      last_r     <= {dct_count, dct_buffer};
      last_vld_r <= 1'b1;
    end
  end

  assign suppress_s = last_vld_r & ({dct_count, dct_buffer} == last_r) & ~mark_s;
`else
  assign suppress_s = 1'b0;
`endif

  // FSM state register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_r <= ST_IDLE;
    else          state_r <= state_next_s;
  end

  // FSM next state; ending waits only for the write already in flight.
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      ST_IDLE, ST_DONE: begin
        if (arm_go_s) state_next_s = ST_ARMED;
        else          state_next_s = state_r;
      end
      ST_ARMED: begin
        if (ending_s)         state_next_s = (~hold_wr_s | tw.tw_ack) ? ST_DONE : ST_ARMED;
        else if (trig_take_s) state_next_s = ST_POST;
        else                  state_next_s = ST_ARMED;
      end
      ST_POST: begin
        if (ending_s)         state_next_s = (~hold_wr_s | tw.tw_ack) ? ST_DONE : ST_POST;
        else if (final_ack_s) state_next_s = ST_DONE;
        else                  state_next_s = ST_POST;
      end
      default: state_next_s = ST_IDLE;
    endcase
  end

  // FSM control strobes; the final post-trigger ack blocks a same-cycle load.
  always_comb begin
    ending_s    = 1'b0;
    arm_go_s    = 1'b0;
    trig_take_s = 1'b0;
    cap_ok_s    = 1'b0;
    post_ack_s  = done_s & pend_post_r & (state_r == ST_POST);
    final_ack_s = post_ack_s & (post_cnt_r == POST_LAST);
    case (state_r)
      ST_IDLE, ST_DONE: begin
        arm_go_s = arm & ~test_ending;
      end
      ST_ARMED: begin
        ending_s    = test_ending | ending_r;
        trig_take_s = trig & ~ending_s;
        cap_ok_s    = ~ending_s;
      end
      ST_POST: begin
        ending_s = test_ending | ending_r;
        cap_ok_s = ~ending_s & ~final_ack_s;
      end
      default: begin
        cap_ok_s = 1'b0;
      end
    endcase
  end

  // Write pointer, wrap flag, post-trigger accounting and trigger bookkeeping.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_r    <= {ADDR_W{1'b0}};
      post_cnt_r  <= {ADDR_W{1'b0}};
      trig_addr_r <= {ADDR_W{1'b0}};
      wrapped_r   <= 1'b0;
      trig_pend_r <= 1'b0;
      pend_post_r <= 1'b0;
      ending_r    <= 1'b0;
    end else begin
      ending_r <= ending_s & ((state_next_s == ST_ARMED) | (state_next_s == ST_POST));
      if (arm_go_s) begin
        wr_ptr_r    <= {ADDR_W{1'b0}};
        post_cnt_r  <= {ADDR_W{1'b0}};
        wrapped_r   <= 1'b0;
        trig_pend_r <= 1'b0;
        pend_post_r <= 1'b0;
      end else begin
        if (done_s)      wr_ptr_r    <= wr_ptr_r + PTR_ONE;
        if (wrap_evt_s)  wrapped_r   <= 1'b1;
        if (post_ack_s)  post_cnt_r  <= post_cnt_r + PTR_ONE;
        if (trig_take_s) trig_addr_r <= load_addr_s;
        // A trigger without a captured payload marks the next captured entry.
        if (hold_loaded_s) begin
          pend_post_r <= (state_r == ST_POST) | trig_take_s;
          trig_pend_r <= 1'b0;
        end else if (trig_take_s) begin
          trig_pend_r <= 1'b1;
        end
      end
    end
  end

  oci_dct_hold_reg #(.ADDR_W(ADDR_W)) u_hold (
    .clk       (clk),
    .reset_n   (reset_n),
    .clr       (arm_go_s),
    .load_req  (cap_req_s),
    .load_addr (load_addr_s),
    .load_data (load_data_s),
    .ack       (tw.tw_ack),
    .wr        (hold_wr_s),
    .addr      (hold_addr_s),
    .data      (hold_data_s),
    .overflow  (overflow_s),
    .loaded    (hold_loaded_s)
  );

  assign tw.tw_wr   = hold_wr_s;
  assign tw.tw_addr = hold_addr_s;
  assign tw.tw_data = hold_data_s;
  assign state      = state_r;
  assign wrapped    = wrapped_r;
  assign overflow   = overflow_s;
  assign trig_addr  = trig_addr_r;

endmodule

// File: doc/oci_dct_trace_ctrl.md
OCI_DCT_TRACE_CTRL -- requirements
Module: oci_dct_trace_ctrl

Interface
REQ-001 SHALL have parameter ADDR_W, default 7: trace RAM address width, 2**ADDR_W entries.
REQ-002 SHALL have parameter POST_TRIG, default 64: entries captured after trigger, range 1..2**ADDR_W-1.
REQ-003 SHALL have port clk, input, 1: single clock; all logic on rising edge.
REQ-004 SHALL have port reset_n, input, 1: asynchronous, active-low reset.
REQ-005 SHALL have ports dct_buffer, input, 30, and dct_count, input, 4: data cycle trace payload and entry tag.
REQ-006 SHALL have port dct_valid, input, 1: payload valid this cycle.
REQ-007 SHALL have ports arm and trig, inputs, 1 each: single-cycle pulses from debug control.
REQ-008 SHALL have port test_ending, input, 1: level; forces capture to finish.
REQ-009 SHALL have ports tw_wr (output, 1), tw_addr (output, ADDR_W) and tw_data (output, 36): write request to trace RAM arbiter.
REQ-010 SHALL have port tw_ack, input, 1: arbiter accepts the current write.
REQ-011 SHALL have ports state, output, 2; wrapped, output, 1; overflow, output, 1; and trig_addr, output, ADDR_W: status.

Function
REQ-012 tw_data SHALL be {trig_mark, wrapped_at_write, dct_count, dct_buffer}, with trig_mark=1 only on the first entry at or after trigger.
REQ-013 FSM states SHALL be IDLE=0, ARMED=1, POST=2, DONE=3.
REQ-014 IDLE->ARMED on arm; write pointer cleared to 0, wrapped and overflow cleared.
REQ-015 ARMED: every valid entry is captured circularly; trig moves to POST and trig_addr latches the pointer of the next write.
REQ-016 POST: after POST_TRIG entries have been accepted by tw_ack, the FSM SHALL go to DONE.
REQ-017 DONE: no captures; arm SHALL restart ARMED per REQ-014.
REQ-018 test_ending in ARMED or POST SHALL go to DONE once any pending write is acked; new entries are ignored from that cycle.
REQ-019 Single holding register: a captured entry asserts tw_wr the next cycle and holds tw_wr, tw_addr and tw_data stable until tw_ack.
REQ-020 A write SHALL complete in the cycle tw_wr&tw_ack; the pointer increments modulo 2**ADDR_W and tw_wr drops unless a new entry loads the register.
REQ-021 When dct_valid arrives in the same cycle as tw_ack, the new entry SHALL load the register, giving back-to-back writes with no bubble.
REQ-022 When dct_valid arrives while the register is full without tw_ack, the entry SHALL be dropped and overflow set sticky.
REQ-023 Pointer wrap from 2**ADDR_W-1 to 0 SHALL set wrapped sticky.
REQ-024 When arm and trig occur in the same cycle in IDLE or DONE, arm SHALL win and trig SHALL be ignored.
REQ-025 trig in IDLE, POST or DONE SHALL be ignored.
REQ-026 When test_ending and arm occur together, test_ending SHALL win.
REQ-027 The payload accompanying trig SHALL be captured as the first POST entry, with trig_mark=1.

Reset
REQ-028 While reset_n=0, the block SHALL asynchronously set state=IDLE, tw_wr=0, tw_addr=0, tw_data=0, wrapped=0, overflow=0, trig_addr=0 and the post counter to 0.
REQ-029 Reset SHALL abandon any pending write immediately; the arbiter must tolerate tw_wr dropping without an ack.

Configuration
REQ-030 Macro OCI_DCT_COMPRESS_EN defined: a valid entry whose {dct_count,dct_buffer} equals the last captured entry SHALL be suppressed, except for the trigger entry; the last-entry compare register clears on arm.
REQ-031 Macro OCI_DCT_COMPRESS_EN undefined: every valid entry SHALL be captured and no compare register SHALL exist.

Structure
REQ-032 Shared package oci_dct_pkg SHALL hold the state encoding, the 36-bit word field offsets and the 30/4 payload widths.
REQ-033 Sub-module oci_dct_hold_reg SHALL implement the holding register, tw_wr/tw_ack handshake and overflow detection; the FSM and pointers stay in the top module.

Verification
REQ-034 Scenario: arm, then 3 valid entries with tw_ack tied 1 -> writes to addresses 0, 1, 2 each one cycle after valid; state=1.
REQ-035 Scenario: ADDR_W=3, arm, 9 entries -> 9th entry written to address 0; wrapped=1.
REQ-036 Scenario: POST_TRIG=4, arm, 2 entries, trig with entry -> trig_addr=2; entry at 2 has bit35=1; DONE after the 4th post ack (address 5).
REQ-037 Scenario: tw_ack held 0 for 3 cycles with valid every cycle -> first entry held stable, next 2 dropped, overflow=1.
REQ-038 Scenario: test_ending in POST with pending write, ack 2 cycles later -> DONE the cycle after ack; no further tw_wr.
REQ-039 Scenario: with OCI_DCT_COMPRESS_EN, 3 identical entries then 1 different -> exactly 2 writes.
